// File: rtl/ifq_multi_line.sv
// ifq_multi_line: instruction fetch queue holding DEPTH cache lines of
// LINE_WORDS words. Keeps a single line request outstanding to the cache,
// issues one instruction per cycle to decode, and on a redirect flushes,
// aborts the outstanding request and restarts mid-line at the target.
// Optional build macro IFQ_PERF_CNT_EN adds flush and starvation counters.
module ifq_multi_line #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [32*LINE_WORDS-1:0] i_line_data,
  input  logic                     i_line_valid,
  input  logic                     i_rd_en,
  input  logic [31:0]              i_jmp_branch_address,
  input  logic                     i_jmp_branch_valid,
  output logic [31:0]              o_fetch_pc,
  output logic                     o_fetch_rd_en,
  output logic                     o_abort,
  output logic [31:0]              o_pc_out,
  output logic [31:0]              o_instr,
  output logic                     o_empty,
  output logic                     o_full
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [15:0]              o_flush_cnt,
  output logic [15:0]              o_starve_cnt
`endif
);

  localparam int unsigned LINE_BYTES = 4 * LINE_WORDS;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);
  localparam int unsigned WI_W       = $clog2(LINE_WORDS);
  localparam int unsigned PTR_W      = $clog2(DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;

  localparam logic [31:0]       LINE_STEP  = 32'(LINE_BYTES);
  localparam logic [31:0]       OFF_MASK   = LINE_STEP - 32'd1;
  localparam logic [31:0]       RESET_LINE = RESET_PC & ~OFF_MASK;
  localparam logic [WI_W-1:0]   RESET_WORD = RESET_PC[OFF_W-1:2];
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [WI_W-1:0]   LAST_WORD  = WI_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ABORT
  } state_t;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       head_pc_q, head_pc_d;
  logic [WI_W-1:0]   rd_word_q, rd_word_d;
  logic [31:0]       pc_out_q, pc_out_d;
  logic [31:0]       instr_q, instr_d;
  logic              empty_q, empty_d;
  line_t             mem_q [DEPTH];
  line_t             mem_d [DEPTH];

  line_t             line_in;
  logic [31:0]       tgt_line;
  logic              wr_en;
  logic              pop;

  assign line_in  = i_line_data;
  assign tgt_line = i_jmp_branch_address & ~OFF_MASK;

  // Next-state: redirect flush, line write, instruction issue and fetch FSM
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    head_pc_d  = head_pc_q;
    rd_word_d  = rd_word_q;
    mem_d      = mem_q;
    wr_en      = 1'b0;
    pop        = 1'b0;

    if (i_jmp_branch_valid) begin
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      head_pc_d  = tgt_line;
      fetch_pc_d = tgt_line;
      rd_word_d  = i_jmp_branch_address[OFF_W-1:2];
      // A line returning in the redirect cycle completes the request, so
      // there is nothing left to abort.
      unique case (state_q)
        REQ:     state_d = i_line_valid ? REQ : ABORT;
        ABORT:   state_d = ABORT;
        default: state_d = REQ;
      endcase
    end else begin
      if (i_rd_en && (count_q != '0)) begin
        if (rd_word_q == LAST_WORD) begin
          pop       = 1'b1;
          rd_word_d = '0;
          rptr_d    = rptr_q + 1'b1;
          head_pc_d = head_pc_q + LINE_STEP;
        end else begin
          rd_word_d = rd_word_q + 1'b1;
        end
      end

      wr_en = (state_q == REQ) && i_line_valid;
      if (wr_en) begin
        mem_d[wptr_q] = line_in;
        wptr_d        = wptr_q + 1'b1;
        fetch_pc_d    = fetch_pc_q + LINE_STEP;
      end

      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      unique case (state_q)
        IDLE:    if (count_q < DEPTH_C) state_d = REQ;
        REQ:     if (wr_en && (count_d == DEPTH_C)) state_d = IDLE;
        ABORT:   state_d = REQ;
        default: state_d = IDLE;
      endcase
    end

    // Registered issue view; reading mem_d lets a freshly written head line
    // show up one cycle after its write.
    empty_d  = (count_d == '0);
    instr_d  = mem_d[rptr_d][rd_word_d];
    pc_out_d = head_pc_d + 32'({rd_word_d, 2'b00});
  end

  // Control and issue state registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_LINE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      head_pc_q  <= RESET_LINE;
      rd_word_q  <= RESET_WORD;
      pc_out_q   <= '0;
      instr_q    <= '0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      head_pc_q  <= head_pc_d;
      rd_word_q  <= rd_word_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      empty_q    <= empty_d;
    end
  end

  // Line storage; contents are qualified by count so no reset is needed
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_fetch_pc    = fetch_pc_q;
  assign o_fetch_rd_en = (state_q == REQ);
  assign o_abort       = (state_q == ABORT);
  assign o_pc_out      = pc_out_q;
  assign o_instr       = instr_q;
  assign o_empty       = empty_q;
  assign o_full        = (count_q == DEPTH_C);

`ifdef IFQ_PERF_CNT_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] starve_cnt_q, starve_cnt_d;

  // Saturating counters: accepted redirects and cycles starved while fetching
  always_comb begin
    flush_cnt_d  = flush_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if (i_jmp_branch_valid && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
    if (empty_q && (state_q == REQ) && (starve_cnt_q != '1)) begin
      starve_cnt_d = starve_cnt_q + 16'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      flush_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      flush_cnt_q  <= flush_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign o_flush_cnt  = flush_cnt_q;
  assign o_starve_cnt = starve_cnt_q;
`endif

endmodule
